// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving a 4:1 mux select, one grant at a time.
// Optional per-grant beat cap enabled with `define MUX_ARB_BURST_LIMIT_EN.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic       busy
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("MAX_BURST must be in 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] g_q, g_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       accept;
  logic       rel;
  logic       arb;
  logic [1:0] arb_ptr;
  logic       pick_found;
  logic [1:0] pick_idx;

  // Search starts just after the last winner, so that winner is lowest priority.
  function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = p + 2'(i);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign busy      = (state_q == GRANT);
  assign out_valid = busy & req[g_q];
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign accept    = out_valid & out_ready;

`ifdef MUX_ARB_BURST_LIMIT_EN
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          limit_hit;

  assign limit_hit = accept && (beat_cnt_q == LAST_BEAT);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_q == GRANT) begin
      if (rel) beat_cnt_d = '0;
      else if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end
`else
  logic limit_hit;
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    rel     = 1'b0;
    arb     = 1'b0;
    arb_ptr = ptr_q;

    case (state_q)
      IDLE: arb = |req;
      GRANT: begin
        rel = ~req[g_q] | limit_hit;
        if (rel) begin
          ptr_d   = g_q;
          arb_ptr = g_q;
          arb     = 1'b1;
        end
      end
      default: ;
    endcase

    {pick_found, pick_idx} = rr_pick(arb_ptr, req);

    // Re-arbitration on release happens in the same edge: no idle bubble.
    if (arb) begin
      if (pick_found) begin
        state_d = GRANT;
        g_d     = pick_idx;
        gnt_d   = 4'b0001 << pick_idx;
        sel_d   = {pick_idx[0], pick_idx[1]};
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= 2'd0;
      ptr_q   <= 2'd3;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed vector bench for mux4_rr_arbiter.
module tb_mux4_rr_arbiter;

`ifdef MUX_ARB_BURST_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  mux4_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       busy;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] es,
                         input logic ev, input logic eb);
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".sel"}, {2'b00, sel}, {2'b00, es});
    chk({tag, ".valid"}, {3'b000, out_valid}, {3'b000, ev});
    chk({tag, ".busy"}, {3'b000, busy}, {3'b000, eb});
  endtask

  function automatic logic [1:0] sel_of(input int idx);
    logic [1:0] g;
    g = 2'(idx);
    return {g[0], g[1]};
  endfunction

  initial begin
    int first;
    int idx;
    rst = 1'b1; req = 4'hF; out_ready = 1'b1;

    //            rst  req      rdy   gnt      sel    v     b
    vecs[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 4'b1110, 1'b1, 4'b0010, 2'b10, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 4'b1101, 1'b1, 4'b0100, 2'b01, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 4'b1011, 1'b1, 4'b1000, 2'b11, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'b01, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b1010, 1'b1, 4'b1000, 2'b11, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 4'b1010, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 2'b10, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b0};

    #1;
    chk_all("reset_async", 4'b0000, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; req = vecs[i].req; out_ready = vecs[i].rdy;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].valid, vecs[i].busy);
    end

    // Requester drop after two beats: valid falls immediately, idle next edge.
    @(negedge clk); req = 4'b0010; out_ready = 1'b1;
    @(posedge clk); #1; chk("drop.gnt", gnt, 4'b0010);
    repeat (2) @(posedge clk);
    @(negedge clk); req = 4'b0000; #1;
    chk("drop.valid", {3'b000, out_valid}, 4'h0);
    chk("drop.gnt_hold", gnt, 4'b0010);
    @(posedge clk); #1;
    chk_all("drop.idle", 4'b0000, 2'b10, 1'b0, 1'b0);

    // Lone requester 3: grant never drops, with or without the burst cap.
    @(negedge clk); req = 4'b1000;
    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) begin
      chk("lone.gnt", gnt, 4'b1000);
      chk("lone.busy", {3'b000, busy}, 4'h1);
      @(posedge clk); #1;
    end
    @(negedge clk); req = 4'b0000;
    @(posedge clk); #1; chk("lone.idle", gnt, 4'b0000);

    // Backpressure on src 2, then exactly four accepted beats.
    @(negedge clk); req = 4'b0100; out_ready = 1'b0;
    @(posedge clk); #1; chk("bp.gnt", gnt, 4'b0100);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; chk("bp.hold", gnt, 4'b0100);
    end
    @(negedge clk); req = 4'b0101; out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.beat%0d", k), gnt, (LIM && k == 4) ? 4'b0001 : 4'b0100);
    end
    @(negedge clk); req = 4'b0000;
    @(posedge clk); #1; chk("bp.idle", gnt, 4'b0000);

    // Full rotation with all requesters held; last release left ptr at 0 (cap) or 2 (no cap).
    first = LIM ? 1 : 3;
    @(negedge clk); req = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      idx = LIM ? (first + k / 4) % 4 : first;
      chk($sformatf("rot%0d.gnt", k), gnt, 4'b0001 << idx);
      chk($sformatf("rot%0d.sel", k), {2'b00, sel}, {2'b00, sel_of(idx)});
      chk($sformatf("rot%0d.busy", k), {3'b000, busy}, 4'h1);
    end

    // Asynchronous reset between edges, then ptr=3 favours req[0] over req[2].
    @(negedge clk); req = 4'b0101;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk_all("arst", 4'b0000, 2'b00, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("arst.hold", 4'b0000, 2'b00, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk_all("arst.rel", 4'b0001, 2'b00, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
